// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: pattern table, blank code, reverse lookup
// and the scan-monitor FSM state type.
package seg7_pkg;

  // Segment order is {a, b, c, d, e, f, g}, active-high.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StLocked
  } scan_state_e;

  // Returns {hit, blank, value[3:0]}; all zero for an unrecognised pattern.
  function automatic logic [5:0] seg7_to_hex(input logic [6:0] pattern);
    logic [5:0] res;
    res = 6'b00_0000;
    case (pattern)
      SEG_0:     res = {2'b10, 4'h0};
      SEG_1:     res = {2'b10, 4'h1};
      SEG_2:     res = {2'b10, 4'h2};
      SEG_3:     res = {2'b10, 4'h3};
      SEG_4:     res = {2'b10, 4'h4};
      SEG_5:     res = {2'b10, 4'h5};
      SEG_6:     res = {2'b10, 4'h6};
      SEG_7:     res = {2'b10, 4'h7};
      SEG_8:     res = {2'b10, 4'h8};
      SEG_9:     res = {2'b10, 4'h9};
      SEG_A:     res = {2'b10, 4'hA};
      SEG_B:     res = {2'b10, 4'hB};
      SEG_C:     res = {2'b10, 4'hC};
      SEG_D:     res = {2'b10, 4'hD};
      SEG_E:     res = {2'b10, 4'hE};
      SEG_F:     res = {2'b10, 4'hF};
      SEG_BLANK: res = {2'b01, 4'h0};
      default:   res = 6'b00_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup of a seven-segment pattern.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       hit,
  output logic       blank
);

  // Table lookup shared with the forward encoder.
  always_comb begin
    {hit, blank, value} = seg7_to_hex(seg);
  end

endmodule

// File: rtl/sevensegment_scan_decoder.sv
// Snoops a multiplexed seven-segment bus and rebuilds the per-digit values,
// committing a digit only after its (index, pattern) sample has been stable.
module sevensegment_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] bin_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd,
  output logic [2:0]              upd_idx,
  output logic                    dec_err,
  output logic                    err_sticky
);

  localparam logic [3:0] Stable = 4'(STABLE_CNT);

  logic                  in_onehot;
  logic [NUM_DIGITS-1:0] dig_en_dec;
  logic [2:0]            in_idx;
  logic                  same;

  logic [2:0] samp_idx_q;
  logic [6:0] samp_seg_q;

  scan_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        commit;

  logic [3:0] dec_value;
  logic       dec_hit;
  logic       dec_blank;

  logic [4*NUM_DIGITS-1:0] bin_q, bin_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic                    upd_q, upd_d;
  logic [2:0]              upd_idx_q, upd_idx_d;
  logic                    dec_err_q, dec_err_d;
  logic                    sticky_q, sticky_d;

  // x & (x-1) clears the lowest set bit, so it is zero only for zero/one-hot.
  assign dig_en_dec = dig_en - NUM_DIGITS'(1);
  assign in_onehot  = (dig_en != '0) && ((dig_en & dig_en_dec) == '0);

  // Index encoder; only meaningful when dig_en is one-hot.
  always_comb begin
    in_idx = 3'd0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (dig_en[i]) in_idx = 3'(i);
    end
  end

  // Previous sample is always one-hot while in Track/Locked, so idx compare is valid.
  assign same = (in_idx == samp_idx_q) && (seg == samp_seg_q);

  // Sample register: remembers the last (idx, seg) pair seen on the bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_idx_q <= 3'd0;
      samp_seg_q <= 7'd0;
    end else begin
      samp_idx_q <= in_idx;
      samp_seg_q <= seg;
    end
  end

  // A commit only fires when the incoming sample equals the registered one,
  // so decoding the registered copy gives the committed pattern.
  seg7_pattern_decode u_decode (
    .seg   (samp_seg_q),
    .value (dec_value),
    .hit   (dec_hit),
    .blank (dec_blank)
  );

  // Stability FSM next-state: count identical samples, commit once per dwell.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (!in_onehot) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StTrack;
          cnt_d   = 4'd1;
        end
        StTrack: begin
          if (same) begin
            if ((cnt_q + 4'd1) >= Stable) begin
              commit  = 1'b1;
              state_d = StLocked;
              cnt_d   = Stable;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cnt_d = 4'd1;
          end
        end
        StLocked: begin
          if (!same) begin
            state_d = StTrack;
            cnt_d   = 4'd1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // FSM state and dwell counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Commit action: update only the addressed digit, or flag an unknown pattern.
  always_comb begin
    bin_d     = bin_q;
    valid_d   = valid_q;
    upd_d     = 1'b0;
    upd_idx_d = upd_idx_q;
    dec_err_d = 1'b0;
    sticky_d  = sticky_q;
    if (commit) begin
      if (dec_hit || dec_blank) begin
        upd_d     = 1'b1;
        upd_idx_d = samp_idx_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (3'(i) == samp_idx_q) begin
            bin_d[4*i +: 4] = dec_blank ? 4'h0 : dec_value;
            valid_d[i]      = dec_hit;
          end
        end
      end else begin
        dec_err_d = 1'b1;
        sticky_d  = 1'b1;
      end
    end
  end

  // Per-digit output registers and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q     <= '0;
      valid_q   <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= 3'd0;
      dec_err_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      valid_q   <= valid_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
      dec_err_q <= dec_err_d;
      sticky_q  <= sticky_d;
    end
  end

  assign bin_out     = bin_q;
  assign digit_valid = valid_q;
  assign upd         = upd_q;
  assign upd_idx     = upd_idx_q;
  assign dec_err     = dec_err_q;
  assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_sevensegment_scan_decoder.sv
// Directed bench for the seven-segment scan decoder (4 digits, 3-sample filter).
module tb_sevensegment_scan_decoder;

  localparam logic [6:0] P1     = 7'b0110000;
  localparam logic [6:0] P2     = 7'b1101101;
  localparam logic [6:0] P3     = 7'b1111001;
  localparam logic [6:0] P5     = 7'b1011011;
  localparam logic [6:0] P7     = 7'b1110000;
  localparam logic [6:0] P8     = 7'b1111111;
  localparam logic [6:0] P9     = 7'b1111011;
  localparam logic [6:0] PA     = 7'b1110111;
  localparam logic [6:0] PF     = 7'b1000111;
  localparam logic [6:0] PBAD   = 7'b1010101;
  localparam logic [6:0] PBLANK = 7'b0000000;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic [15:0] bin_out;
  logic [3:0]  digit_valid;
  logic        upd;
  logic [2:0]  upd_idx;
  logic        dec_err;
  logic        err_sticky;

  int checks;
  int errors;
  int upd_cnt;
  int err_cnt;

  logic [6:0] scan_pat [4];

  sevensegment_scan_decoder #(
    .NUM_DIGITS (4),
    .STABLE_CNT (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .dig_en      (dig_en),
    .bin_out     (bin_out),
    .digit_valid (digit_valid),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .dec_err     (dec_err),
    .err_sticky  (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 ns after each and tallying pulses.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (upd) upd_cnt++;
      if (dec_err) err_cnt++;
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    upd_cnt = 0;
    err_cnt = 0;
    scan_pat[0] = P1;
    scan_pat[1] = PA;
    scan_pat[2] = P9;
    scan_pat[3] = PF;

    rst_n  = 1'b0;
    dig_en = 4'b0000;
    seg    = PBLANK;
    step(2);
    check("rst_bin", 32'(bin_out), 32'h0);
    check("rst_valid", 32'(digit_valid), 32'h0);
    check("rst_upd", 32'(upd), 32'h0);
    check("rst_upd_idx", 32'(upd_idx), 32'h0);
    check("rst_dec_err", 32'(dec_err), 32'h0);
    check("rst_sticky", 32'(err_sticky), 32'h0);
    rst_n = 1'b1;
    step(1);

    // Single digit: '3' on digit 0, commit after the third edge.
    dig_en = 4'b0001;
    seg    = P3;
    step(2);
    check("d3_early_upd", 32'(upd), 32'h0);
    step(1);
    check("d3_upd", 32'(upd), 32'h1);
    check("d3_upd_idx", 32'(upd_idx), 32'h0);
    check("d3_nibble", 32'(bin_out[3:0]), 32'h3);
    check("d3_valid", 32'(digit_valid), 32'h1);
    step(1);
    check("d3_pulse_width", 32'(upd), 32'h0);
    upd_cnt = 0;
    step(4);
    check("d3_one_commit", 32'(upd_cnt), 32'h0);

    // Scan 1, A, 9, F across digits 0..3 with 5-cycle dwells.
    upd_cnt = 0;
    for (int d = 0; d < 4; d++) begin
      dig_en = 4'b0001 << d;
      seg    = scan_pat[d];
      step(5);
    end
    check("scan_bin", 32'(bin_out), 32'hF9A1);
    check("scan_valid", 32'(digit_valid), 32'hF);
    check("scan_upd_cnt", 32'(upd_cnt), 32'd4);

    // Too-short dwell, then multi-hot enables: neither may commit.
    upd_cnt = 0;
    dig_en  = 4'b0001;
    seg     = P8;
    step(2);
    dig_en = 4'b0000;
    step(1);
    dig_en = 4'b0110;
    step(4);
    check("short_upd_cnt", 32'(upd_cnt), 32'h0);
    check("short_bin", 32'(bin_out), 32'hF9A1);

    // Unknown pattern on digit 2.
    upd_cnt = 0;
    err_cnt = 0;
    dig_en  = 4'b0100;
    seg     = PBAD;
    step(4);
    check("bad_err_cnt", 32'(err_cnt), 32'd1);
    check("bad_sticky", 32'(err_sticky), 32'h1);
    check("bad_bin", 32'(bin_out), 32'hF9A1);
    check("bad_valid", 32'(digit_valid), 32'hF);
    check("bad_upd_cnt", 32'(upd_cnt), 32'h0);

    // Digit 1 shows 8, then is blanked.
    dig_en = 4'b0010;
    seg    = P8;
    step(3);
    check("d8_upd", 32'(upd), 32'h1);
    check("d8_upd_idx", 32'(upd_idx), 32'h1);
    check("d8_bin", 32'(bin_out), 32'hF981);
    seg = PBLANK;
    step(3);
    check("blank_upd", 32'(upd), 32'h1);
    check("blank_upd_idx", 32'(upd_idx), 32'h1);
    check("blank_valid", 32'(digit_valid), 32'hD);
    check("blank_bin", 32'(bin_out), 32'hF901);
    check("blank_sticky", 32'(err_sticky), 32'h1);

    // Pattern change exactly at the would-be commit edge restarts the count.
    dig_en = 4'b0001;
    seg    = P7;
    step(2);
    seg = P2;
    step(1);
    check("restart_no_upd", 32'(upd), 32'h0);
    check("restart_keep", 32'(bin_out[3:0]), 32'h1);
    step(1);
    check("restart_no_upd2", 32'(upd), 32'h0);
    step(1);
    check("restart_upd", 32'(upd), 32'h1);
    check("restart_nibble", 32'(bin_out[3:0]), 32'h2);

    // Reset on the second cycle of a dwell, then a full dwell is needed again.
    seg = P5;
    step(1);
    rst_n = 1'b0;
    step(1);
    check("mid_rst_bin", 32'(bin_out), 32'h0);
    check("mid_rst_valid", 32'(digit_valid), 32'h0);
    check("mid_rst_sticky", 32'(err_sticky), 32'h0);
    check("mid_rst_upd", 32'(upd), 32'h0);
    rst_n = 1'b1;
    step(2);
    check("post_rst_early", 32'(upd), 32'h0);
    check("post_rst_valid0", 32'(digit_valid), 32'h0);
    step(1);
    check("post_rst_upd", 32'(upd), 32'h1);
    check("post_rst_bin", 32'(bin_out), 32'h0005);
    check("post_rst_valid", 32'(digit_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevensegment_scan_decoder.md
# sevensegment_scan_decoder

Receive-side counterpart of the binary-to-seven-segment converter: snoops a time-multiplexed seven-segment display bus (segment lines plus one-hot digit enables) and reconstructs the 4-bit binary value shown on each digit. A per-digit stability filter rejects scan transitions and ghosting; unknown patterns raise an error. Used in display self-check loops and as the bench-side monitor for display drivers.

## Interface
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8)
- STABLE_CNT, 3, consecutive identical samples required before a digit is decoded (2..15)

- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- seg  in  7  segment lines, active-high; seg[6]=a, seg[5]=b … seg[0]=g
- dig_en  in  NUM_DIGITS  digit enables, active-high, one-hot while a digit is driven
- bin_out  out  4*NUM_DIGITS  decoded values; digit i at bin_out[4i+3:4i]
- digit_valid  out  NUM_DIGITS  bit i set when digit i holds a decoded hex value
- upd  out  1  one-cycle pulse: a digit was just decoded or blanked
- upd_idx  out  3  digit index for the current upd pulse
- dec_err  out  1  one-cycle pulse: stable but unrecognised pattern
- err_sticky  out  1  set by any dec_err, cleared only by reset

## Operation
- Pattern table (abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111; blank=0000000.
- Each clock, the sample (idx, seg) is registered, where idx is the position of the single set bit of dig_en.
- FSM states:
  - IDLE: dig_en not one-hot (zero or multi-hot). Counter cleared, no decode. Moves to TRACK on a one-hot sample, with counter=1.
  - TRACK: sample equal to the previous sample -> counter+1. Sample differs -> counter=1 and stay in TRACK. On reaching STABLE_CNT -> commit, go to LOCKED.
  - LOCKED: already committed for this dwell; hold while the sample is unchanged. Changed one-hot sample -> TRACK with counter=1. Non-one-hot sample -> IDLE.
- Commit action for digit idx:
  - Recognised hex: bin_out nibble=value, digit_valid[idx]=1, upd=1.
  - Blank: nibble=0, digit_valid[idx]=0, upd=1.
  - Unknown: nibble and valid unchanged, dec_err=1, err_sticky=1, no upd.
- Exactly one commit per stable dwell, regardless of dwell length.
- Other digits are never disturbed by a commit.
- Counter width is 4 bits; it saturates at STABLE_CNT and cannot wrap.

## Timing
- Reset (rst_n=0 at an edge): bin_out=0, digit_valid=0, upd=0, upd_idx=0, dec_err=0, err_sticky=0, FSM=IDLE, counter=0. A reset mid-dwell discards the partial count.
- Latency: if a new sample is first captured at edge k, outputs update at edge k+STABLE_CNT-1. With STABLE_CNT=3, a change before edge 1 gives results after edge 3.
- upd/upd_idx and dec_err are high for exactly one cycle after the commit edge.
- A sample change at the commit edge itself restarts the count. No commit occurs at that edge.
- Back-to-back dwells on different digits commit independently. The minimum spacing between commits is STABLE_CNT cycles.

## Structure
- Package seg7_pkg holds the 16 pattern localparams, SEG_BLANK, and a function seg7_to_hex returning {hit, blank, value[3:0]}. The forward encoder shares this package.
- One combinational sub-module, seg7_pattern_decode (seg -> value, hit, blank), instantiated once on the registered sample.
- Top level contains the one-hot check and index encoder, the sample register, the counter, the FSM and the per-digit output registers.

## Test plan
- Reset, then dig_en=0001 and seg=1111001 held for 3 cycles -> after the third edge, bin_out[3:0]=3, digit_valid=0001, upd=1 and upd_idx=0 for one cycle.
- Scan digits 0..3 with patterns for 1, A, 9, F, dwell 5 cycles each -> bin_out=16'hF9A1, digit_valid=1111, exactly four upd pulses.
- Dwell of 2 cycles with STABLE_CNT=3 -> no upd and bin_out unchanged. dig_en=0110 for 4 cycles -> no commit.
- seg=1010101 on digit 2 held for 4 cycles -> a single dec_err pulse, err_sticky=1, digit 2 unchanged.
- Digit 1 showing 8, then blank 0000000 held for 3 cycles -> digit_valid[1]=0, nibble=0, upd with upd_idx=1.
- Assert rst_n=0 on the second cycle of a dwell -> all outputs reset. After release, a full STABLE_CNT dwell is again required before a commit.
